// File: rtl/pu_riscv_multiplier_seq.sv
// Iterative RV32M/RV64M multiplier (MUL/MULH/MULHSU/MULHU/MULW).
// Unsigned shift-add on operand magnitudes, RADIX_BITS multiplier bits per cycle, sign fix-up at the end.
module pu_riscv_multiplier_seq #(
  parameter int XLEN       = 64,
  parameter int ILEN       = 32,
  parameter int RADIX_BITS = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ex_stall,
  input  logic            id_bubble,
  input  logic [ILEN-1:0] id_instr,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic [1:0]      st_xlen,
  output logic            mul_stall,
  output logic            mul_bubble,
  output logic [XLEN-1:0] mul_r
);

  localparam int CNT_W = $clog2(XLEN / RADIX_BITS + 1);
  localparam logic [CNT_W-1:0] N_XLEN = CNT_W'(XLEN / RADIX_BITS);
  localparam logic [CNT_W-1:0] N_32   = CNT_W'(32 / RADIX_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OP32  = 7'b0111011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mul_bubble_q, mul_bubble_d;
  logic [XLEN-1:0]     mul_r_q, mul_r_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic                neg_q, neg_d;
  logic                hi_q, hi_d;
  logic                w32_q, w32_d;

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = '0;
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  // Magnitude within the effective width; a W-bit most-negative value maps to 2^(W-1).
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg,
                                                input logic w32);
    logic [XLEN-1:0] n;
    n = neg ? -v : v;
    return w32 ? zext32(n[31:0]) : n;
  endfunction

  function automatic logic [XLEN-1:0] select_result(input logic [2*XLEN-1:0] p, input logic hi,
                                                    input logic w32);
    if (w32) return sext32(hi ? p[63:32] : p[31:0]);
    return hi ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
  endfunction

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       is_op, is_w, issue;
  logic       unused_instr;

  assign opcode       = id_instr[6:0];
  assign funct3       = id_instr[14:12];
  assign funct7       = id_instr[31:25];
  assign unused_instr = ^{id_instr};

  assign is_op = (funct7 == F7_MULDIV) && (opcode == OPC_OP) && !funct3[2];
  assign is_w  = (XLEN == 64) && (funct7 == F7_MULDIV) && (opcode == OPC_OP32) &&
                 (funct3 == 3'b000);
  // Gated by rstn so mul_stall reads as idle while reset is held.
  assign issue = rstn && (state_q == IDLE) && !id_bubble && (is_op || is_w) && !ex_stall;

  logic            w32, sgn_a, sgn_b;
  logic [XLEN-1:0] a_trunc, b_trunc, a_mag, b_mag;

  always_comb begin
    w32     = (XLEN == 32) || is_w || (st_xlen == 2'b01);
    a_trunc = w32 ? zext32(opA[31:0]) : opA;
    b_trunc = w32 ? zext32(opB[31:0]) : opB;
    sgn_a   = (funct3 != 3'b011) && (w32 ? opA[31] : opA[XLEN-1]);
    sgn_b   = !funct3[1] && (w32 ? opB[31] : opB[XLEN-1]);
    a_mag   = magnitude(a_trunc, sgn_a, w32);
    b_mag   = magnitude(b_trunc, sgn_b, w32);
  end

  logic [2*XLEN-1:0] pp, sum, prod_fix;

  always_comb begin
    pp = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (mplier_q[i]) pp = pp + (mcand_q << i);
    end
    sum      = acc_q + pp;
    prod_fix = neg_q ? -sum : sum;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    w32_d    = w32_q;
    mul_r_d  = mul_r_q;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          state_d  = BUSY;
          cnt_d    = w32 ? N_32 : N_XLEN;
          acc_d    = '0;
          mcand_d  = {{XLEN{1'b0}}, a_mag};
          mplier_d = b_mag;
          neg_d    = sgn_a ^ sgn_b;
          hi_d     = (funct3 != 3'b000);
          w32_d    = w32;
        end
      end
      BUSY: begin
        cnt_d    = cnt_q - CNT_LAST;
        acc_d    = sum;
        mcand_d  = mcand_q << RADIX_BITS;
        mplier_d = mplier_q >> RADIX_BITS;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          acc_d   = prod_fix;
          mul_r_d = select_result(prod_fix, hi_q, w32_q);
        end
      end
      DONE: begin
        // Same instruction is still on id_instr here, so never issue from DONE.
        if (!ex_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mul_bubble_d = (state_d != DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mul_bubble_q <= 1'b1;
      mul_r_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mul_bubble_q <= mul_bubble_d;
      mul_r_q      <= mul_r_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    neg_q    <= neg_d;
    hi_q     <= hi_d;
    w32_q    <= w32_d;
  end

  assign mul_stall  = issue || (state_q == BUSY);
  assign mul_bubble = mul_bubble_q;
  assign mul_r      = mul_r_q;

endmodule
